// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU selects,
// sequencer states, instruction classes and the datapath strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    typedef enum logic [3:0] {
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
        ST_HALT, ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_ADDI, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic pco;
        logic pc_inc;
        logic mari;
        logic mdri;
        logic mdro;
        logic iri;
        logic mem_read;
        logic mem_write;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
        logic ryi;
        logic zi;
        logic zlowo;
        logic csigno;
    } strobes_t;

    // Steps that hold a memory command until mem_done or timeout.
    function automatic logic is_wait_state(state_e s, op_class_e c);
        return (s == ST_T1) || (s == ST_T6 && c == CLS_LD) || (s == ST_T7 && c == CLS_ST);
    endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: maps an opcode to its instruction class
// and the ALU function used in the execute step.
module ctrl_opcode_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output op_class_e               op_class,
    output logic [ALU_OP_WIDTH-1:0] alu_op
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_OP_WIDTH'(ALU_ADD);
        unique case (opcode)
            OPCODE_WIDTH'(OPC_LD):   op_class = CLS_LD;
            OPCODE_WIDTH'(OPC_LDI):  op_class = CLS_LDI;
            OPCODE_WIDTH'(OPC_ST):   op_class = CLS_ST;
            OPCODE_WIDTH'(OPC_ADD):  op_class = CLS_ALU;
            OPCODE_WIDTH'(OPC_SUB): begin
                op_class = CLS_ALU;
                alu_op   = ALU_OP_WIDTH'(ALU_SUB);
            end
            OPCODE_WIDTH'(OPC_AND): begin
                op_class = CLS_ALU;
                alu_op   = ALU_OP_WIDTH'(ALU_AND);
            end
            OPCODE_WIDTH'(OPC_OR): begin
                op_class = CLS_ALU;
                alu_op   = ALU_OP_WIDTH'(ALU_OR);
            end
            OPCODE_WIDTH'(OPC_ADDI): op_class = CLS_ADDI;
            OPCODE_WIDTH'(OPC_NOP):  op_class = CLS_NOP;
            OPCODE_WIDTH'(OPC_HALT): op_class = CLS_HALT;
            default:                 op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute micro-step sequencer that owns every control
// strobe of the datapath, with memory-done handshake, timeout fault and halt.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int IR_WIDTH     = 32,
    parameter int OPCODE_WIDTH = 5,
    parameter int ALU_OP_WIDTH = 4,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [IR_WIDTH-1:0]     ir,
    input  logic                    mem_done,
    output logic                    pco,
    output logic                    pc_inc,
    output logic                    mari,
    output logic                    mdri,
    output logic                    mdro,
    output logic                    iri,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    gra,
    output logic                    grb,
    output logic                    grc,
    output logic                    rin,
    output logic                    rout,
    output logic                    baout,
    output logic                    ryi,
    output logic                    zi,
    output logic                    zlowo,
    output logic                    csigno,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    run,
    output logic                    fault,
    output logic                    illegal
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    op_class_e               class_q, class_d;
    logic [ALU_OP_WIDTH-1:0] alu_sel_q, alu_sel_d;
    logic                    started_q;

    op_class_e               dec_class;
    logic [ALU_OP_WIDTH-1:0] dec_alu_op;
    logic                    in_wait;

    strobes_t                strb;
    logic [ALU_OP_WIDTH-1:0] alu_op_c;
    logic                    run_c, fault_c, illegal_c;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[IR_WIDTH-OPCODE_WIDTH-1:0];

    ctrl_opcode_decode #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_decode (
        .opcode   (ir[IR_WIDTH-1 -: OPCODE_WIDTH]),
        .op_class (dec_class),
        .alu_op   (dec_alu_op)
    );

    assign in_wait = is_wait_state(state_q, class_q);

    // The class is captured at decode so execute steps ignore later IR changes.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        class_d    = class_q;
        alu_sel_d  = alu_sel_q;
        unique case (state_q)
            ST_T0: if (started_q) state_d = ST_T1;
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                class_d   = dec_class;
                alu_sel_d = dec_alu_op;
                unique case (dec_class)
                    CLS_NOP, CLS_ILLEGAL: state_d = ST_T0;
                    CLS_HALT:             state_d = ST_HALT;
                    default:              state_d = ST_T4;
                endcase
            end
            ST_T4: state_d = ST_T5;
            ST_T5: state_d = (class_q == CLS_LD || class_q == CLS_ST) ? ST_T6 : ST_T0;
            ST_T6: state_d = ST_T7;
            ST_T7: state_d = ST_T0;
            ST_HALT, ST_FAULT: state_d = state_q;
            default: state_d = ST_FAULT;
        endcase
        if (in_wait && !mem_done) begin
            if (wait_cnt_q == WAIT_LAST) begin
                state_d = ST_FAULT;
            end else begin
                state_d    = state_q;
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_T0;
            wait_cnt_q <= '0;
            class_q    <= CLS_NOP;
            alu_sel_q  <= '0;
            started_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            class_q    <= class_d;
            alu_sel_q  <= alu_sel_d;
            started_q  <= 1'b1;
        end
    end

    // Moore decode of the state; mdri additionally tracks mem_done in read waits.
    always_comb begin
        strb      = '0;
        alu_op_c  = '0;
        run_c     = 1'b1;
        fault_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (state_q)
            ST_T0: begin
                strb.pco    = started_q;
                strb.mari   = started_q;
                strb.pc_inc = started_q;
            end
            ST_T1: begin
                strb.mem_read = 1'b1;
                strb.mdri     = mem_done;
            end
            ST_T2: begin
                strb.mdro = 1'b1;
                strb.iri  = 1'b1;
            end
            ST_T3: begin
                unique case (dec_class)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        strb.grb   = 1'b1;
                        strb.baout = 1'b1;
                        strb.ryi   = 1'b1;
                    end
                    CLS_ALU, CLS_ADDI: begin
                        strb.grb  = 1'b1;
                        strb.rout = 1'b1;
                        strb.ryi  = 1'b1;
                    end
                    CLS_ILLEGAL: illegal_c = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                strb.zi = 1'b1;
                if (class_q == CLS_ALU) begin
                    strb.grc = 1'b1;
                    strb.rout = 1'b1;
                    alu_op_c = alu_sel_q;
                end else begin
                    strb.csigno = 1'b1;
                end
            end
            ST_T5: begin
                strb.zlowo = 1'b1;
                if (class_q == CLS_LD || class_q == CLS_ST) begin
                    strb.mari = 1'b1;
                end else begin
                    strb.gra = 1'b1;
                    strb.rin = 1'b1;
                end
            end
            ST_T6: begin
                if (class_q == CLS_LD) begin
                    strb.mem_read = 1'b1;
                    strb.mdri     = mem_done;
                end else begin
                    strb.gra  = 1'b1;
                    strb.rout = 1'b1;
                    strb.mdri = 1'b1;
                end
            end
            ST_T7: begin
                if (class_q == CLS_LD) begin
                    strb.mdro = 1'b1;
                    strb.gra  = 1'b1;
                    strb.rin  = 1'b1;
                end else begin
                    strb.mem_write = 1'b1;
                end
            end
            ST_HALT: run_c = 1'b0;
            ST_FAULT: begin
                run_c   = 1'b0;
                fault_c = 1'b1;
            end
            default: run_c = 1'b0;
        endcase
    end

    assign pco       = strb.pco;
    assign pc_inc    = strb.pc_inc;
    assign mari      = strb.mari;
    assign mdri      = strb.mdri;
    assign mdro      = strb.mdro;
    assign iri       = strb.iri;
    assign mem_read  = strb.mem_read;
    assign mem_write = strb.mem_write;
    assign gra       = strb.gra;
    assign grb       = strb.grb;
    assign grc       = strb.grc;
    assign rin       = strb.rin;
    assign rout      = strb.rout;
    assign baout     = strb.baout;
    assign ryi       = strb.ryi;
    assign zi        = strb.zi;
    assign zlowo     = strb.zlowo;
    assign csigno    = strb.csigno;
    assign alu_op    = alu_op_c;
    assign run       = run_c;
    assign fault     = fault_c;
    assign illegal   = illegal_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: a micro-step table model expands each
// instruction into per-cycle expected outputs, compared every cycle.
module tb_control_sequencer;

    localparam int TMO = 15;

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR = 5'b00110, OP_ADDI = 5'b01100, OP_NOP = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [24:0] M_PCO = 25'd1 << 0,   M_PC_INC = 25'd1 << 1, M_MARI = 25'd1 << 2;
    localparam logic [24:0] M_MDRI = 25'd1 << 3,  M_MDRO = 25'd1 << 4,   M_IRI = 25'd1 << 5;
    localparam logic [24:0] M_MRD = 25'd1 << 6,   M_MWR = 25'd1 << 7,    M_GRA = 25'd1 << 8;
    localparam logic [24:0] M_GRB = 25'd1 << 9,   M_GRC = 25'd1 << 10,   M_RIN = 25'd1 << 11;
    localparam logic [24:0] M_ROUT = 25'd1 << 12, M_BAOUT = 25'd1 << 13, M_RYI = 25'd1 << 14;
    localparam logic [24:0] M_ZI = 25'd1 << 15,   M_ZLOWO = 25'd1 << 16, M_CSIGNO = 25'd1 << 17;
    localparam logic [24:0] M_RUN = 25'd1 << 18,  M_FAULT = 25'd1 << 19, M_ILLEGAL = 25'd1 << 20;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_done = 1'b0;

    logic pco, pc_inc, mari, mdri, mdro, iri, mem_read, mem_write;
    logic gra, grb, grc, rin, rout, baout, ryi, zi, zlowo, csigno;
    logic [3:0] alu_op;
    logic run, fault, illegal;
    logic [24:0] act;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done),
        .pco(pco), .pc_inc(pc_inc), .mari(mari), .mdri(mdri), .mdro(mdro), .iri(iri),
        .mem_read(mem_read), .mem_write(mem_write),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .ryi(ryi), .zi(zi), .zlowo(zlowo), .csigno(csigno),
        .alu_op(alu_op), .run(run), .fault(fault), .illegal(illegal)
    );

    assign act = {alu_op, illegal, fault, run, csigno, zlowo, zi, ryi, baout, rout, rin,
                  grc, grb, gra, mem_write, mem_read, iri, mdro, mdri, mari, pc_inc, pco};

    typedef struct {
        logic [24:0] v;
        bit          d;
    } step_t;

    step_t q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    bit    stopped;
    logic [4:0] legal [9] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_NOP};

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    function automatic bit rnd_done();
        return $urandom_range(0, 3) == 0;
    endfunction

    function automatic logic [24:0] alu_f(int a);
        return 25'(a) << 21;
    endfunction

    task automatic push(logic [24:0] v, bit d);
        step_t s;
        s.v = v;
        s.d = d;
        q.push_back(s);
    endtask

    task automatic push_s(logic [24:0] v);
        push(v | M_RUN, rnd_done());
    endtask

    // A memory step: w cycles without mem_done, then one with it; w >= TMO times out.
    task automatic gen_wait(logic [24:0] cmd, logic [24:0] on_done, int w, output bit to);
        if (w >= TMO) begin
            repeat (TMO) push(cmd | M_RUN, 1'b0);
            to = 1'b1;
        end else begin
            repeat (w) push(cmd | M_RUN, 1'b0);
            push(cmd | on_done | M_RUN, 1'b1);
            to = 1'b0;
        end
    endtask

    task automatic gen_instr(logic [4:0] op, int w1, int w2, int tail);
        bit to;
        q.delete();
        stopped = 1'b0;
        push_s(M_PCO | M_PC_INC | M_MARI);
        gen_wait(M_MRD, M_MDRI, w1, to);
        if (!to) begin
            push_s(M_MDRO | M_IRI);
            case (op)
                OP_LD: begin
                    push_s(M_GRB | M_BAOUT | M_RYI);
                    push_s(M_CSIGNO | M_ZI);
                    push_s(M_ZLOWO | M_MARI);
                    gen_wait(M_MRD, M_MDRI, w2, to);
                    if (!to) push_s(M_MDRO | M_GRA | M_RIN);
                end
                OP_LDI: begin
                    push_s(M_GRB | M_BAOUT | M_RYI);
                    push_s(M_CSIGNO | M_ZI);
                    push_s(M_ZLOWO | M_GRA | M_RIN);
                end
                OP_ST: begin
                    push_s(M_GRB | M_BAOUT | M_RYI);
                    push_s(M_CSIGNO | M_ZI);
                    push_s(M_ZLOWO | M_MARI);
                    push_s(M_GRA | M_ROUT | M_MDRI);
                    gen_wait(M_MWR, '0, w2, to);
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    push_s(M_GRB | M_ROUT | M_RYI);
                    push_s(M_GRC | M_ROUT | M_ZI | alu_f(int'(op) - 3));
                    push_s(M_ZLOWO | M_GRA | M_RIN);
                end
                OP_ADDI: begin
                    push_s(M_GRB | M_ROUT | M_RYI);
                    push_s(M_CSIGNO | M_ZI);
                    push_s(M_ZLOWO | M_GRA | M_RIN);
                end
                OP_NOP: push_s('0);
                OP_HALT: begin
                    push_s('0);
                    stopped = 1'b1;
                    repeat (tail) push('0, rnd_done());
                end
                default: push_s(M_ILLEGAL);
            endcase
        end
        if (to) begin
            stopped = 1'b1;
            repeat (tail) push(M_FAULT, rnd_done());
        end
    endtask

    task automatic run_steps(int limit, string tag);
        for (int i = 0; i < limit && i < q.size(); i++) begin
            mem_done = q[i].d;
            @(negedge clock);
            check($sformatf("%s cyc%0d", tag, i), {7'd0, act}, {7'd0, q[i].v});
            @(posedge clock);
            #1;
        end
        mem_done = 1'b0;
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase with cycle 0 next.
    task automatic do_reset();
        #1;
        mem_done = 1'b0;
        clear = 1'b0;
        #1;
        check("reset drop", {7'd0, act}, {7'd0, M_RUN});
        @(posedge clock);
        #1;
        check("reset held", {7'd0, act}, {7'd0, M_RUN});
        clear = 1'b1;
        @(negedge clock);
        check("pre-start idle", {7'd0, act}, {7'd0, M_RUN});
        @(posedge clock);
        #1;
    endtask

    task automatic do_instr(logic [4:0] op, int w1, int w2, int tail, string tag);
        ir = {op, 27'($urandom)};
        gen_instr(op, w1, w2, tail);
        run_steps(q.size(), tag);
        if (stopped) do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] op;
        int w1, w2;

        @(posedge clock);
        #1;
        do_reset();

        ir = {OP_ADD, 27'h0};
        gen_instr(OP_ADD, 0, 0, 0);
        check("model add length", q.size(), 32'd6);
        check("model add T0", {7'd0, q[0].v}, {7'd0, M_PCO | M_MARI | M_PC_INC | M_RUN});
        check("model add T4", {7'd0, q[4].v}, {7'd0, M_GRC | M_ROUT | M_ZI | M_RUN});
        run_steps(q.size(), "add0");

        ir = {OP_LD, 27'h123};
        gen_instr(OP_LD, 3, 3, 0);
        check("model ld3 length", q.size(), 32'd14);
        check("model ld3 last", {7'd0, q[13].v}, {7'd0, M_MDRO | M_GRA | M_RIN | M_RUN});
        run_steps(q.size(), "ld3");

        do_instr(OP_ST, 1, 2, 0, "st");

        ir = {5'b11111, 27'h0};
        gen_instr(5'b11111, 0, 0, 0);
        check("model illegal length", q.size(), 32'd4);
        check("model illegal T3", {7'd0, q[3].v}, {7'd0, M_ILLEGAL | M_RUN});
        run_steps(q.size(), "ill");

        do_instr(OP_SUB, 0, 0, 0, "sub");
        do_instr(OP_AND, 2, 0, 0, "and");
        do_instr(OP_OR, 0, 0, 0, "or");
        do_instr(OP_LDI, 0, 0, 0, "ldi");
        do_instr(OP_ADDI, 1, 0, 0, "addi");
        do_instr(OP_NOP, 0, 0, 0, "nop");
        do_instr(OP_LD, 14, 14, 0, "ld max wait");
        do_instr(OP_HALT, 0, 0, 100, "halt");

        ir = {OP_ADD, 27'h0};
        gen_instr(OP_ADD, TMO, 0, 5);
        check("model timeout c15", {7'd0, q[15].v}, {7'd0, M_MRD | M_RUN});
        check("model timeout c16", {7'd0, q[16].v}, {7'd0, M_FAULT});
        run_steps(q.size(), "timeout");
        do_reset();

        do_instr(OP_ST, 0, TMO, 4, "st timeout");

        ir = {OP_LD, 27'h55};
        gen_instr(OP_LD, 0, 0, 0);
        run_steps(5, "ld clr");
        #1;
        check("ld T5 before clear", {7'd0, act}, {7'd0, q[5].v});
        do_reset();
        do_instr(OP_ADD, 0, 0, 0, "after clear");

        for (int k = 0; k < 200; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) op = OP_HALT;
            else if (r < 25) op = 5'($urandom_range(0, 31));
            else op = legal[$urandom_range(0, 8)];
            w1 = ($urandom_range(0, 29) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 3);
            w2 = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
            do_instr(op, w1, w2, $urandom_range(1, 6), $sformatf("rnd%0d op%02h", k, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired micro-step sequencer for the RISC datapath. It replaces the hand-scripted T0..Tn control stimulus with a parametrised fetch/decode/execute state machine that drives every datapath control strobe. It supports a memory-done handshake with a timeout, halt/fault states, and decode of load, load-immediate, store, ALU-register, add-immediate, nop and halt. It sits beside `datapath`, reads `ir` back from it, and owns all of its control inputs.

## Interface
- `IR_WIDTH`, 32: instruction register width; opcode is `ir[IR_WIDTH-1 -: OPCODE_WIDTH]`.
- `OPCODE_WIDTH`, 5: opcode field width.
- `ALU_OP_WIDTH`, 4: width of the ALU function select.
- `MEM_TIMEOUT`, 15: maximum number of wait cycles for `mem_done` before a fault.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `ir` in IR_WIDTH: current instruction, fed back from the datapath.
- `mem_done` in 1: memory completion strobe, one cycle wide.
- `pco`, `pc_inc`, `mari`, `mdri`, `mdro`, `iri` out 1 each: PC, MAR, MDR and IR strobes.
- `mem_read`, `mem_write` out 1 each: memory commands, held high through the wait.
- `gra`, `grb`, `grc`, `rin`, `rout`, `baout` out 1 each: register-file select and enable strobes.
- `ryi`, `zi`, `zlowo`, `csigno` out 1 each: Y in, Z in, Z-low out and sign-extended constant out.
- `alu_op` out ALU_OP_WIDTH: ALU function; ADD=0, SUB=1, AND=2, OR=3.
- `run` out 1: high unless the block is in HALT or FAULT.
- `fault` out 1: sticky; high in FAULT.
- `illegal` out 1: one-cycle pulse when an unknown opcode is decoded.

## Operation
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011. Every other value is illegal.
- Fetch is common to all instructions:
  - T0: `pco`, `mari`, `pc_inc`.
  - T1: `mem_read`; waits for `mem_done`.
  - T2: `mdri`, `mdro` into `iri` path. Exactly: `mdri` is asserted in the T1 cycle that sees `mem_done`; T2 asserts `mdro`, `iri`.
- T3 decodes the opcode and branches by class:
  - ld: T3 `grb`,`baout`,`ryi`; T4 `csigno`,`alu_op`=ADD,`zi`; T5 `zlowo`,`mari`; T6 `mem_read` wait, then `mdri`; T7 `mdro`,`gra`,`rin`.
  - ldi: T3 `grb`,`baout`,`ryi`; T4 `csigno`,ADD,`zi`; T5 `zlowo`,`gra`,`rin`.
  - st: T3–T5 as ld; T6 `gra`,`rout`,`mdri`; T7 `mem_write` wait.
  - add/sub/and/or: T3 `grb`,`rout`,`ryi`; T4 `grc`,`rout`,`alu_op`=op,`zi`; T5 `zlowo`,`gra`,`rin`.
  - addi: T3 `grb`,`rout`,`ryi`; T4 `csigno`,ADD,`zi`; T5 `zlowo`,`gra`,`rin`.
  - nop: returns to T0.
  - halt: enters HALT.
  - illegal: pulses `illegal` and returns to T0.
- After the last step of a class, the next state is T0.
- HALT and FAULT are terminal; only `clear` leaves them.

## Timing
- Reset: state T0; all strobes 0, `alu_op`=0, `fault`=0, `illegal`=0, `run`=1. The first fetch starts on the first edge after `clear` deasserts.
- Outputs are a Moore decode of the registered state. Each strobe is high for the whole state cycle.
- Wait states (T1, ld T6, st T7) hold their command. A 4-bit wait counter starts at 0 on entry.
  - `mem_done` arriving in the same cycle as entry allows a 1-cycle stay.
  - If the counter reaches MEM_TIMEOUT without `mem_done`, the next state is FAULT: `fault`=1, `run`=0, all strobes 0.
- `mem_done` outside a wait state is ignored.
- Instruction latency with zero-wait memory: nop 4 cycles, ALU/ldi/addi 6, ld/st 8. Each memory wait cycle adds 1.
- `clear` asserted mid-instruction forces T0 immediately (asynchronously), regardless of state.

## Structure
- Shared package `cpu_ctrl_pkg` holds the opcode constants, ALU op constants and the state enum (T0..T7, HALT, FAULT).
- One sub-module, `ctrl_opcode_decode`: combinational mapping from opcode to class (LD, LDI, ST, ALU, ADDI, NOP, HALT, ILLEGAL) plus `alu_op`.

## Test plan
- Zero-wait add (`ir`=0x18000000 style, opcode 00011): `mem_done` on the first T1 cycle. Expect `pco`/`mari` at cycle 0, `iri` at cycle 2, `zi` with `alu_op`=0 at cycle 4, `rin` at cycle 5, T0 again at cycle 6.
- ld with 3-cycle memory waits in both T1 and T6: total 14 cycles; `mdri` coincides with each `mem_done`; `gra`,`rin` in the final cycle.
- st: `mem_write` is held until `mem_done`, never overlaps `mem_read`, and `mdri` is high in T6.
- Timeout: hold `mem_done`=0 in T1 for 16 cycles. Expect `fault`=1 and `run`=0 from cycle 16 on, with all strobes 0, until `clear`.
- Opcode 11111 (illegal): one-cycle `illegal` in T3, then `pco` in the next cycle. Opcode 11011 (halt): `run` drops and stays low for 100 cycles.
- `clear` pulsed low during ld T5: all strobes drop within the same cycle, then a fresh fetch starts with `pco`.
